mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage 16-bit pipeline, between the EX/MEM buffer and the register file write-back. It performs data-memory loads and stores over a req/ack handshake and stalls the upstream pipeline while an access is outstanding. It forwards write-back results into store data and registers all write-back signals into an internal MEM/WB buffer. It also produces the final write-back data word.

## Interface
Parameters:
- none; widths fixed at 16-bit data, 4-bit register address, 16-bit memory address

Ports:
- clock  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low
- ALU, RD1, R0  in  16 each  EX/MEM outputs: address/result, store data, R0 value
- RR1, wAddr  in  4 each  store-source register, destination register
- muxWB, memRead, memWrite, regWrite, regWrite0  in  1 each  EX/MEM control
- mem_rdata  in  16  data memory read data, valid when mem_ack=1
- mem_ack  in  1  data memory completion, one-cycle pulse
- mem_req, mem_we  out  1 each  memory request, write enable
- mem_addr, mem_wdata  out  16 each  memory address, store data
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- bufferMEMWB_ALU, bufferMEMWB_memData, bufferMEMWB_R0  out  16 each
- bufferMEMWB_wAddr  out  4
- bufferMEMWB_muxWB, bufferMEMWB_regWrite, bufferMEMWB_regWrite0  out  1 each
- wbData  out  16  = bufferMEMWB_muxWB ? bufferMEMWB_memData : bufferMEMWB_ALU

## Operation
- access = memRead | memWrite; memRead and memWrite both high is treated as a write.
- FSM states: IDLE, BUSY.
- IDLE, access=0: no request. The MEM/WB buffer loads the inputs on the edge (memData=0). stall=0.
- IDLE, access=1:
  - Drive mem_req=1, mem_we=memWrite, mem_addr=ALU, mem_wdata=forwarded store data.
  - Latch addr, wdata and we into hold registers.
  - Go to BUSY. stall=1. The MEM/WB buffer loads a bubble.
  - mem_ack is ignored in IDLE.
- BUSY: mem_req=1, and address, data and we are driven from the hold registers.
  - mem_ack=0: stay in BUSY. stall=1. The MEM/WB buffer loads a bubble.
  - mem_ack=1: stall=0. On the edge, the MEM/WB buffer loads the EX/MEM inputs, with memData=mem_rdata for a read or 0 for a write. Go to IDLE.
- Bubble: regWrite=0, regWrite0=0, muxWB=0, wAddr=0, all data fields 0.
- Store forwarding (evaluated in IDLE only):
  - If bufferMEMWB_regWrite and bufferMEMWB_wAddr==RR1, store data = wbData.
  - Else if bufferMEMWB_regWrite0 and RR1==0, store data = bufferMEMWB_R0.
  - Else store data = RD1.
- When no request is active, mem_addr, mem_wdata and mem_we are 0.

## Timing
- Reset (asynchronous, low):
  - State=IDLE and hold registers=0.
  - Every bufferMEMWB_* output is 0, so wbData=0.
  - mem_req, mem_we and stall are 0 while reset is low and no access is presented.
- Reset asserted mid-access: any outstanding access is abandoned. mem_req drops in the same cycle. A late mem_ack after reset is ignored because the FSM is in IDLE.
- Non-memory op: 1 cycle through the stage. It is visible on bufferMEMWB_* one edge after being presented.
- Memory op with ack in its first BUSY cycle: 2 cycles, stall high for exactly 1 cycle.
- Memory op in general: N wait cycles in BUSY give N+1 stall cycles.
- Back-to-back memory ops:
  - The second op is presented in the cycle after ack, and IDLE issues it immediately.
  - The first op, already in MEM/WB, is a valid forwarding source.
- Upstream holds the EX/MEM outputs stable while stall=1; the block relies on this.

## Structure
- Shared pipeline package holds:
  - the 2-state FSM encoding (IDLE=1'b0, BUSY=1'b1)
  - constants DATA_W=16 and REG_W=4
  - the bubble field values
- The MEM/WB buffer is a natural sub-module, bufferMEMWB, with a load/bubble select. The block instantiates it.
- The FSM, hold registers and forwarding mux stay in mem_stage.

## Test plan
- Reset low with inputs nonzero:
  - Required: all bufferMEMWB_*=0, wbData=0, mem_req=0, stall=0.
- ALU op (ALU=0x1234, wAddr=3, regWrite=1, muxWB=0):
  - Required, next edge: bufferMEMWB_ALU=0x1234, wAddr=3, wbData=0x1234. stall never asserted.
- Load (ALU=0x0040, memRead=1, muxWB=1, wAddr=5), mem_ack after 2 BUSY cycles with rdata=0xBEEF:
  - Required: mem_addr=0x0040 throughout, stall high 3 cycles, one bubble per stall cycle.
  - Then bufferMEMWB_memData=0xBEEF and wbData=0xBEEF.
- Store (ALU=0x0010, RD1=0x1111, RR1=5) issued right after the load to r5 completes:
  - Required: mem_we=1, mem_wdata=0xBEEF (forwarded, not 0x1111).
- Store with RR1=0 after an op writing R0=0x00AA via regWrite0:
  - Required: mem_wdata=0x00AA.
- Reset pulsed low during BUSY, then mem_ack pulsed after release:
  - Required: mem_req=0 immediately, state IDLE, the ack has no effect, MEM/WB stays 0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: FSM encoding, widths,
// the MEM/WB record layout and its bubble value.
package mem_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // One MEM/WB buffer entry; field order is irrelevant to the datapath.
    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] r0;
        logic [REG_W-1:0]  w_addr;
        logic              mux_wb;
        logic              reg_write;
        logic              reg_write0;
    } memwb_t;

    // A bubble writes nothing and carries all-zero data.
    localparam memwb_t MEMWB_BUBBLE = '{
        alu:        '0,
        mem_data:   '0,
        r0:         '0,
        w_addr:     '0,
        mux_wb:     1'b0,
        reg_write:  1'b0,
        reg_write0: 1'b0
    };

    // Final write-back word selected from a MEM/WB entry.
    function automatic logic [DATA_W-1:0] wb_select(input memwb_t e);
        return e.mux_wb ? e.mem_data : e.alu;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the memory.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_stage_bufferMEMWB.sv
// MEM/WB pipeline buffer: loads the offered entry or a bubble every edge.
module bufferMEMWB
    import mem_stage_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   load,
    input  memwb_t d,
    output memwb_t q
);

    memwb_t entry_d;
    memwb_t entry_q;

    // Choose between the offered entry and a bubble.
    always_comb begin
        entry_d = load ? d : MEMWB_BUBBLE;
    end

    // Buffer register; reset empties it to a bubble.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!reset) entry_q <= MEMWB_BUBBLE;
        else        entry_q <= entry_d;
    end

    assign q = entry_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over req/ack, stalls upstream
// while an access is outstanding, forwards write-back into store data and
// feeds the MEM/WB buffer.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] ALU,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] R0,
    input  logic [REG_W-1:0]  RR1,
    input  logic [REG_W-1:0]  wAddr,
    input  logic              muxWB,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              regWrite,
    input  logic              regWrite0,
    mem_stage_if.master       mem,
    output logic              stall,
    output logic [DATA_W-1:0] bufferMEMWB_ALU,
    output logic [DATA_W-1:0] bufferMEMWB_memData,
    output logic [DATA_W-1:0] bufferMEMWB_R0,
    output logic [REG_W-1:0]  bufferMEMWB_wAddr,
    output logic              bufferMEMWB_muxWB,
    output logic              bufferMEMWB_regWrite,
    output logic              bufferMEMWB_regWrite0,
    output logic [DATA_W-1:0] wbData
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
    logic              hold_we_q, hold_we_d;

    memwb_t            wb_q;
    memwb_t            wb_in;
    logic              wb_load;
    logic              access;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] store_data;

    // A simultaneous read+write request is issued as a write.
    assign access  = memRead | memWrite;
    assign wb_data = wb_select(wb_q);

    // Store-data forwarding from the instruction currently in MEM/WB.
    always_comb begin
        store_data = RD1;
        if (wb_q.reg_write && (wb_q.w_addr == RR1)) store_data = wb_data;
        else if (wb_q.reg_write0 && (RR1 == '0))     store_data = wb_q.r0;
    end

    // Next state, memory bus drive, stall and MEM/WB load/bubble select.
    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        state_d       = state_q;
        hold_addr_d   = hold_addr_q;
        hold_wdata_d  = hold_wdata_q;
        hold_we_d     = hold_we_q;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        stall         = 1'b0;
        wb_load       = 1'b1;
        wb_in         = '{alu: ALU, mem_data: '0, r0: R0, w_addr: wAddr,
                          mux_wb: muxWB, reg_write: regWrite,
                          reg_write0: regWrite0};
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    mem.mem_req   = 1'b1;
                    mem.mem_we    = memWrite;
                    mem.mem_addr  = ALU;
                    mem.mem_wdata = store_data;
                    hold_addr_d   = ALU;
                    hold_wdata_d  = store_data;
                    hold_we_d     = memWrite;
                    stall         = 1'b1;
                    wb_load       = 1'b0;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = hold_we_q;
                mem.mem_addr  = hold_addr_q;
                mem.mem_wdata = hold_wdata_q;
                if (mem.mem_ack) begin
                    wb_in.mem_data = hold_we_q ? '0 : mem.mem_rdata;
                    state_d        = IDLE;
                end else begin
                    stall   = 1'b1;
                    wb_load = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and hold registers; reset abandons any outstanding access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            hold_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_we_q    <= hold_we_d;
        end
    end

    bufferMEMWB u_buffer_memwb (
        .clock (clock),
        .reset (reset),
        .load  (wb_load),
        .d     (wb_in),
        .q     (wb_q)
    );

    assign bufferMEMWB_ALU       = wb_q.alu;
    assign bufferMEMWB_memData   = wb_q.mem_data;
    assign bufferMEMWB_R0        = wb_q.r0;
    assign bufferMEMWB_wAddr     = wb_q.w_addr;
    assign bufferMEMWB_muxWB     = wb_q.mux_wb;
    assign bufferMEMWB_regWrite  = wb_q.reg_write;
    assign bufferMEMWB_regWrite0 = wb_q.reg_write0;
    assign wbData                = wb_data;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized
// instruction streams against an instruction-level model with a memory array.
module tb_mem_stage;

    typedef struct packed {
        logic [15:0] alu, rd1, r0;
        logic [3:0]  rr1, waddr;
        logic        mux_wb, mem_read, mem_write, reg_write, reg_write0;
    } instr_t;

    typedef struct packed {
        logic [15:0] alu, mem_data, r0;
        logic [3:0]  waddr;
        logic        mux_wb, reg_write, reg_write0;
    } wb_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] ALU = '0, RD1 = '0, R0 = '0;
    logic [3:0]  RR1 = '0, wAddr = '0;
    logic        muxWB = 0, memRead = 0, memWrite = 0, regWrite = 0, regWrite0 = 0;
    logic        stall;
    logic [15:0] bufferMEMWB_ALU, bufferMEMWB_memData, bufferMEMWB_R0, wbData;
    logic [3:0]  bufferMEMWB_wAddr;
    logic        bufferMEMWB_muxWB, bufferMEMWB_regWrite, bufferMEMWB_regWrite0;

    mem_stage_if bus ();

    mem_stage dut (
        .clock(clock), .reset(reset),
        .ALU(ALU), .RD1(RD1), .R0(R0), .RR1(RR1), .wAddr(wAddr),
        .muxWB(muxWB), .memRead(memRead), .memWrite(memWrite),
        .regWrite(regWrite), .regWrite0(regWrite0),
        .mem(bus.master), .stall(stall),
        .bufferMEMWB_ALU(bufferMEMWB_ALU), .bufferMEMWB_memData(bufferMEMWB_memData),
        .bufferMEMWB_R0(bufferMEMWB_R0), .bufferMEMWB_wAddr(bufferMEMWB_wAddr),
        .bufferMEMWB_muxWB(bufferMEMWB_muxWB), .bufferMEMWB_regWrite(bufferMEMWB_regWrite),
        .bufferMEMWB_regWrite0(bufferMEMWB_regWrite0), .wbData(wbData)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model state: what MEM/WB must hold now, the last retired instruction,
    // and the data memory contents.
    wb_t         exp_wb = '0;
    wb_t         last   = '0;
    logic [15:0] mem_model [logic [15:0]];
    int          last_stalls;
    logic [15:0] last_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_read_val(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] wb_word(input wb_t e);
        return e.mux_wb ? e.mem_data : e.alu;
    endfunction

    function automatic wb_t retire(input instr_t in, input logic [15:0] md);
        wb_t r;
        r.alu = in.alu; r.mem_data = md; r.r0 = in.r0; r.waddr = in.waddr;
        r.mux_wb = in.mux_wb; r.reg_write = in.reg_write; r.reg_write0 = in.reg_write0;
        return r;
    endfunction

    // Store data the architecture must see: result of the previous instruction
    // overrides the register-file read when it targets the source register.
    function automatic logic [15:0] expect_store(input instr_t in, input wb_t prev);
        if (prev.reg_write && prev.waddr == in.rr1) return wb_word(prev);
        if (prev.reg_write0 && in.rr1 == 4'd0)     return prev.r0;
        return in.rd1;
    endfunction

    task automatic apply(input instr_t in);
        ALU = in.alu; RD1 = in.rd1; R0 = in.r0; RR1 = in.rr1; wAddr = in.waddr;
        muxWB = in.mux_wb; memRead = in.mem_read; memWrite = in.mem_write;
        regWrite = in.reg_write; regWrite0 = in.reg_write0;
    endtask

    // Every cycle the MEM/WB outputs must equal the model's view.
    always @(negedge clock) begin
        check("wb_alu",    bufferMEMWB_ALU,       exp_wb.alu);
        check("wb_memdat", bufferMEMWB_memData,   exp_wb.mem_data);
        check("wb_r0",     bufferMEMWB_R0,        exp_wb.r0);
        check("wb_waddr",  bufferMEMWB_wAddr,     exp_wb.waddr);
        check("wb_muxwb",  bufferMEMWB_muxWB,     exp_wb.mux_wb);
        check("wb_rw",     bufferMEMWB_regWrite,  exp_wb.reg_write);
        check("wb_rw0",    bufferMEMWB_regWrite0, exp_wb.reg_write0);
        check("wbData",    wbData,                wb_word(exp_wb));
    end

    // Run one instruction to retirement; memory acks after n_wait BUSY cycles.
    task automatic run(input instr_t in, input int n_wait);
        logic        is_wr;
        logic [15:0] fwd, rd;
        bit          ack;
        apply(in);
        fwd = expect_store(in, last);
        last_wdata = fwd;
        last_stalls = 0;
        if (!(in.mem_read || in.mem_write)) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            bus.mem_rdata = 16'($urandom);
            @(negedge clock);
            check("nop_stall", stall, 0);
            check("nop_req", bus.mem_req, 0);
            check("nop_we", bus.mem_we, 0);
            check("nop_addr", bus.mem_addr, 0);
            check("nop_wdata", bus.mem_wdata, 0);
            @(posedge clock); #1;
            bus.mem_ack = 1'b0;
            last = retire(in, 16'h0);
            exp_wb = last;
        end else begin
            is_wr = in.mem_write;
            @(negedge clock);
            check("iss_req", bus.mem_req, 1);
            check("iss_we", bus.mem_we, is_wr);
            check("iss_addr", bus.mem_addr, in.alu);
            check("iss_wdata", bus.mem_wdata, is_wr ? fwd : bus.mem_wdata);
            check("iss_stall", stall, 1);
            last_stalls++;
            @(posedge clock); #1;
            exp_wb = '0;
            for (int i = 0; i <= n_wait; i++) begin
                ack = (i == n_wait);
                rd = (ack && !is_wr) ? mem_read_val(in.alu) : 16'($urandom);
                bus.mem_ack = ack;
                bus.mem_rdata = rd;
                @(negedge clock);
                check("busy_req", bus.mem_req, 1);
                check("busy_we", bus.mem_we, is_wr);
                check("busy_addr", bus.mem_addr, in.alu);
                if (is_wr) check("busy_wdata", bus.mem_wdata, fwd);
                check("busy_stall", stall, !ack);
                if (stall) last_stalls++;
                @(posedge clock); #1;
                bus.mem_ack = 1'b0;
                if (ack) begin
                    if (is_wr) mem_model[in.alu] = fwd;
                    last = retire(in, is_wr ? 16'h0 : rd);
                    exp_wb = last;
                end else begin
                    exp_wb = '0;
                end
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t in;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;

        // Reset held low with nonzero, non-memory inputs.
        in = '{alu: 16'hFFFF, rd1: 16'h1357, r0: 16'hAAAA, rr1: 4'd7, waddr: 4'd9,
               mux_wb: 1'b1, mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b1, reg_write0: 1'b1};
        apply(in);
        repeat (2) @(posedge clock);
        #1;
        check("rst_wb_alu", bufferMEMWB_ALU, 16'h0000);
        check("rst_wbData", wbData, 16'h0000);
        check("rst_req", bus.mem_req, 0);
        check("rst_stall", stall, 0);
        reset = 1'b1;

        // ALU op passes in one edge.
        in = '{alu: 16'h1234, rd1: 16'h0, r0: 16'h0, rr1: 4'd0, waddr: 4'd3,
               mux_wb: 1'b0, mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b1, reg_write0: 1'b0};
        run(in, 0);
        check("alu_wb_alu", bufferMEMWB_ALU, 16'h1234);
        check("alu_wb_waddr", bufferMEMWB_wAddr, 4'd3);
        check("alu_wbData", wbData, 16'h1234);

        // Load with two wait cycles.
        mem_model[16'h0040] = 16'hBEEF;
        in = '{alu: 16'h0040, rd1: 16'h0, r0: 16'h0, rr1: 4'd1, waddr: 4'd5,
               mux_wb: 1'b1, mem_read: 1'b1, mem_write: 1'b0, reg_write: 1'b1, reg_write0: 1'b0};
        run(in, 2);
        check("ld_stalls", last_stalls, 3);
        check("ld_memdata", bufferMEMWB_memData, 16'hBEEF);
        check("ld_wbData", wbData, 16'hBEEF);

        // Store of r5 right after the load: forwarded data.
        in = '{alu: 16'h0010, rd1: 16'h1111, r0: 16'h0, rr1: 4'd5, waddr: 4'd0,
               mux_wb: 1'b0, mem_read: 1'b0, mem_write: 1'b1, reg_write: 1'b0, reg_write0: 1'b0};
        run(in, 0);
        check("st_fwd_wdata", last_wdata, 16'hBEEF);
        check("st_mem", mem_read_val(16'h0010), 16'hBEEF);

        // R0 write followed by a store of R0.
        in = '{alu: 16'h0000, rd1: 16'h0, r0: 16'h00AA, rr1: 4'd2, waddr: 4'd0,
               mux_wb: 1'b0, mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0, reg_write0: 1'b1};
        run(in, 0);
        in = '{alu: 16'h0011, rd1: 16'h5555, r0: 16'h0, rr1: 4'd0, waddr: 4'd0,
               mux_wb: 1'b0, mem_read: 1'b0, mem_write: 1'b1, reg_write: 1'b0, reg_write0: 1'b0};
        run(in, 1);
        check("st_r0_wdata", last_wdata, 16'h00AA);
        check("st_r0_mem", mem_read_val(16'h0011), 16'h00AA);

        // Reset during BUSY, then a late ack.
        in = '{alu: 16'h0020, rd1: 16'h0, r0: 16'h0, rr1: 4'd0, waddr: 4'd6,
               mux_wb: 1'b1, mem_read: 1'b1, mem_write: 1'b0, reg_write: 1'b1, reg_write0: 1'b0};
        apply(in);
        @(posedge clock); #1;
        exp_wb = '0;
        check("rb_busy_req", bus.mem_req, 1);
        apply('0);
        reset = 1'b0;
        last = '0;
        #1;
        check("rb_req_drop", bus.mem_req, 0);
        check("rb_stall", stall, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'hFFFF;
        @(negedge clock);
        check("rb_late_req", bus.mem_req, 0);
        @(posedge clock); #1;
        bus.mem_ack = 1'b0;
        check("rb_memdata", bufferMEMWB_memData, 16'h0000);
        check("rb_rw", bufferMEMWB_regWrite, 0);

        // Randomized instruction stream over a small address/register space.
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            in.mem_read   = (kind < 3) || (kind == 9);
            in.mem_write  = (kind >= 3 && kind < 6) || (kind == 9);
            in.alu        = (in.mem_read || in.mem_write) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            in.rd1        = 16'($urandom);
            in.r0         = 16'($urandom);
            in.rr1        = 4'($urandom_range(0, 3));
            in.waddr      = 4'($urandom_range(0, 3));
            in.mux_wb     = 1'($urandom_range(0, 1));
            in.reg_write  = 1'($urandom_range(0, 1));
            in.reg_write0 = 1'($urandom_range(0, 1));
            run(in, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
